// File: rtl/frame_packer.sv
// frame_packer
//   Buffers 1..MAX_WORDS 16-bit payload words for one channel, computes
//   CRC-16/XMODEM over them, then emits a gap-free frame on data_out:
//   HEADER(2 words), {8'h00,chan}, payload, CRC (optionally inverted),
//   TRAILER(2 words), followed by IDLE_GAP zero words.
// Ports
//   clk_in     clock, rising edge
//   rst        asynchronous reset, active-high
//   start_i    frame request, sampled in IDLE only
//   chan_i     one-hot channel select, sampled with start_i
//   len_i      payload length in words, sampled with start_i
//   crc_inv_i  send ~CRC when set, sampled with start_i
//   s_valid    payload word valid
//   s_data     payload word (first word is most significant)
//   s_ready    payload word accepted on s_valid & s_ready
//   data_out   registered frame stream
//   busy_o     high in every state except IDLE
//   done_o     one-cycle pulse with the last trailer word
//   cfg_err_o  one-cycle pulse after a rejected start_i
module frame_packer #(
  parameter int          MAX_WORDS = 8,
  parameter int          IDLE_GAP  = 2,
  parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER   = 32'h0E0E0E0E
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  chan_i,
  input  logic [3:0]  len_i,
  input  logic        crc_inv_i,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic [15:0] data_out,
  output logic        busy_o,
  output logic        done_o,
  output logic        cfg_err_o
);

  localparam int CNT_MAX = (MAX_WORDS > IDLE_GAP) ? MAX_WORDS : IDLE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [3:0]    MAX_LEN  = 4'(MAX_WORDS);
  localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, HDR1, HDR2, CHAN, PAY, CRC, TRL1, TRL2, GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    chan_q, chan_d;
  logic [3:0]    len_q, len_d;
  logic          inv_q, inv_d;
  logic [15:0]   data_d;
  logic          done_d;
  logic          cfg_err_d;
  logic          buf_we;
  logic [CW-1:0] len_last;
  logic          cfg_ok;
  logic [15:0]   pay_buf [MAX_WORDS];

  // 16 bits folded in per word, MSB first (poly 0x1021).
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [15:0] word);
    logic [15:0] c;
    logic [15:0] w;
    logic        fb;
    c = crc_in;
    w = word;
    for (int unsigned i = 0; i < 16; i++) begin
      fb = c[15] ^ w[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      w  = {w[14:0], 1'b0};
    end
    return c;
  endfunction

  assign len_last = CW'(len_q) - CW'(1);
  assign cfg_ok   = ($countones(chan_i) == 1) && (len_i != 4'd0) && (len_i <= MAX_LEN);
  assign s_ready  = (state_q == LOAD);
  assign busy_o   = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    chan_d    = chan_q;
    len_d     = len_q;
    inv_d     = inv_q;
    cfg_err_d = 1'b0;
    buf_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            chan_d  = chan_i;
            len_d   = len_i;
            inv_d   = crc_inv_i;
            crc_d   = '0;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          buf_we = 1'b1;
          crc_d  = crc16_word(crc_q, s_data);
          // cnt is reused as the payload read index, so restart it here.
          if (cnt_q == len_last) begin
            cnt_d   = '0;
            state_d = HDR1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HDR1: state_d = HDR2;
      HDR2: state_d = CHAN;
      CHAN: state_d = PAY;
      PAY: begin
        if (cnt_q == len_last) begin
          cnt_d   = '0;
          state_d = CRC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CRC:  state_d = TRL1;
      TRL1: state_d = TRL2;
      TRL2: begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // data_out is registered: select the word for the state being entered.
  always_comb begin
    data_d = '0;
    done_d = 1'b0;
    unique case (state_d)
      HDR1: data_d = HEADER[31:16];
      HDR2: data_d = HEADER[15:0];
      CHAN: data_d = {8'h00, chan_d};
      PAY:  data_d = pay_buf[cnt_d[IW-1:0]];
      CRC:  data_d = inv_d ? ~crc_d : crc_d;
      TRL1: data_d = TRAILER[31:16];
      TRL2: begin
        data_d = TRAILER[15:0];
        done_d = 1'b1;
      end
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      chan_q    <= '0;
      len_q     <= '0;
      inv_q     <= 1'b0;
      data_out  <= '0;
      done_o    <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      chan_q    <= chan_d;
      len_q     <= len_d;
      inv_q     <= inv_d;
      data_out  <= data_d;
      done_o    <= done_d;
      cfg_err_o <= cfg_err_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (buf_we) pay_buf[cnt_q[IW-1:0]] <= s_data;
  end

endmodule

// File: tb/tb_frame_packer.sv
module tb_frame_packer;

  localparam int          MAXW = 8;
  localparam int          GAPN = 2;
  localparam logic [31:0] HDR  = 32'hE0E0E0E0;
  localparam logic [31:0] TRL  = 32'h0E0E0E0E;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  chan_i;
  logic [3:0]  len_i;
  logic        crc_inv_i;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] data_out;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] words [MAXW];
  logic [15:0] last_crc;

  frame_packer #(
    .MAX_WORDS (MAXW),
    .IDLE_GAP  (GAPN),
    .HEADER    (HDR),
    .TRAILER   (TRL)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start_i   (start_i),
    .chan_i    (chan_i),
    .len_i     (len_i),
    .crc_inv_i (crc_inv_i),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .data_out  (data_out),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .cfg_err_o (cfg_err_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference CRC: bit-serial long division over the whole payload message.
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic        b;
    c = '0;
    for (int w = 0; w < n; w++)
      for (int k = 15; k >= 0; k--) begin
        b = words[w][k] ^ c[15];
        c = {c[14:0], 1'b0};
        if (b) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data"},  32'(data_out),  32'h0);
    check({tag, "_ready"}, 32'(s_ready),   32'h0);
    check({tag, "_busy"},  32'(busy_o),    32'h0);
    check({tag, "_done"},  32'(done_o),    32'h0);
  endtask

  // stall < 0: random 0..3 idle cycles before each word; else that many before words after the first.
  task automatic run_frame(input logic [7:0] ch, input int len, input logic inv,
                           input int stall, input bit poke);
    logic [15:0]  exp [$];
    logic [15:0]  c;
    int unsigned  ns;
    c = crc_ref(len);
    if (inv) c = ~c;
    exp = {};
    exp.push_back(HDR[31:16]);
    exp.push_back(HDR[15:0]);
    exp.push_back({8'h00, ch});
    for (int i = 0; i < len; i++) exp.push_back(words[i]);
    exp.push_back(c);
    exp.push_back(TRL[31:16]);
    exp.push_back(TRL[15:0]);

    check("pre_busy", 32'(busy_o), 32'h0);
    start_i   = 1'b1;
    chan_i    = ch;
    len_i     = 4'(len);
    crc_inv_i = inv;
    step();
    start_i   = 1'b0;
    chan_i    = 8'($urandom);
    len_i     = 4'($urandom);
    crc_inv_i = 1'($urandom);
    check("cfg_err_ok", 32'(cfg_err_o), 32'h0);
    check("load_busy",  32'(busy_o),    32'h1);

    for (int w = 0; w < len; w++) begin
      if (stall < 0) ns = $urandom_range(3, 0);
      else           ns = (w == 0) ? 0 : stall;
      for (int unsigned s = 0; s < ns; s++) begin
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        check("stall_data",  32'(data_out), 32'h0);
        check("stall_ready", 32'(s_ready),  32'h1);
        step();
      end
      s_valid = 1'b1;
      s_data  = words[w];
      check("load_ready", 32'(s_ready), 32'h1);
      step();
    end
    // Stray valid after the last word must be ignored.
    s_valid = 1'b1;
    s_data  = 16'hDEAD;

    for (int i = 0; i < exp.size(); i++) begin
      check("frame_word",  32'(data_out), 32'(exp[i]));
      check("frame_done",  32'(done_o),   32'(i == exp.size() - 1));
      check("frame_ready", 32'(s_ready),  32'h0);
      if (i == len + 3) last_crc = data_out;
      s_valid = 1'b0;
      if (poke && i == 3) begin
        start_i = 1'b1;
        chan_i  = 8'h04;
        len_i   = 4'd3;
      end else begin
        start_i = 1'b0;
      end
      step();
    end
    start_i = 1'b0;
    for (int g = 0; g < GAPN; g++) begin
      check("gap_data", 32'(data_out), 32'h0);
      check("gap_busy", 32'(busy_o),   32'h1);
      check("gap_done", 32'(done_o),   32'h0);
      step();
    end
    check("end_busy", 32'(busy_o), 32'h0);
    step();
    check("no_queue_busy", 32'(busy_o), 32'h0);
  endtask

  task automatic reject(input logic [7:0] ch, input logic [3:0] len);
    start_i = 1'b1;
    chan_i  = ch;
    len_i   = len;
    step();
    start_i = 1'b0;
    check("rej_pulse", 32'(cfg_err_o), 32'h1);
    check("rej_busy",  32'(busy_o),    32'h0);
    step();
    check("rej_clear", 32'(cfg_err_o), 32'h0);
    check("rej_idle",  32'(busy_o),    32'h0);
  endtask

  initial begin
    rst       = 1'b0;
    start_i   = 1'b0;
    chan_i    = '0;
    len_i     = '0;
    crc_inv_i = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    #2 rst = 1'b1;
    // Reset with live stimulus.
    start_i = 1'b1;
    chan_i  = 8'h01;
    len_i   = 4'd1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_zero_outputs("rst");
      check("rst_cfg_err", 32'(cfg_err_o), 32'h0);
    end
    rst     = 1'b0;
    start_i = 1'b0;
    s_valid = 1'b0;
    check_zero_outputs("rel");
    step();
    check("rel_busy", 32'(busy_o), 32'h0);

    // Single word, channel 1.
    words[0] = 16'h0001;
    run_frame(8'h01, 1, 1'b0, 0, 1'b0);
    check("crc_w0001", 32'(last_crc), 32'h1021);

    // Two words with three idle cycles between them.
    words[0] = 16'h0001;
    words[1] = 16'h0000;
    run_frame(8'h02, 2, 1'b0, 3, 1'b0);
    check("crc_w0001_0000", 32'(last_crc), 32'h3730);

    // Inverted CRC.
    words[0] = 16'h0001;
    run_frame(8'h01, 1, 1'b1, 0, 1'b0);
    check("crc_inv", 32'(last_crc), 32'hEFDE);

    // Full length, start_i poked during payload.
    for (int i = 0; i < MAXW; i++) words[i] = 16'($urandom);
    run_frame(8'h80, MAXW, 1'b0, -1, 1'b1);

    // Rejected configurations.
    reject(8'h03, 4'd1);
    reject(8'h00, 4'd1);
    reject(8'h01, 4'd0);
    reject(8'h01, 4'd9);
    reject(8'h20, 4'd15);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      int ln;
      ln = int'($urandom_range(MAXW, 1));
      for (int i = 0; i < MAXW; i++) words[i] = 16'($urandom);
      run_frame(8'h01 << $urandom_range(7, 0), ln, 1'($urandom), -1, 1'($urandom));
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < MAXW; i++) words[i] = 16'($urandom);
    start_i = 1'b1;
    chan_i  = 8'h10;
    len_i   = 4'd8;
    step();
    start_i = 1'b0;
    for (int w = 0; w < MAXW; w++) begin
      s_valid = 1'b1;
      s_data  = words[w];
      step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_busy", 32'(busy_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("mid_rst");
    step();
    check_zero_outputs("mid_hold");
    rst = 1'b0;
    step();
    check("mid_idle", 32'(busy_o), 32'h0);
    check("mid_data", 32'(data_out), 32'h0);

    // Frame after abort behaves normally.
    words[0] = 16'h0001;
    run_frame(8'h01, 1, 1'b0, 0, 1'b0);
    check("crc_after_abort", 32'(last_crc), 32'h1021);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
